s6_icap_boot_ctrl: RTL and testbench

Sequencer and arbiter in front of the Spartan-6 ICAP Wishbone slave. Shares the single ICAP port between a CPU Wishbone pass-through and an internal multiboot sequencer. On `start`, the sequencer issues the full IPROG command stream (sync, GENERAL1..4, CMD=IPROG) so the FPGA reboots from a given SPI flash address. Sits on the CPU Wishbone bus, in place of a direct connection to the ICAP slave.

---
 rtl/s6_icap_boot_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_s6_icap_boot_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s6_icap_boot_ctrl.sv
// Arbiter and IPROG sequencer in front of the Spartan-6 ICAP Wishbone slave.
// Optional macro S6_ICAP_BOOT_FALLBACK_EN adds the GENERAL3/GENERAL4 fallback words.
module s6_icap_boot_ctrl #(
  parameter int unsigned TIMEOUT     = 1023,
  parameter logic [7:0]  FLASH_RD_OP = 8'h0B
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        start,
  input  logic [23:0] boot_addr,
  input  logic [23:0] fallback_addr,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef S6_ICAP_BOOT_FALLBACK_EN
  localparam int unsigned NumWords = 16;
`else
  localparam int unsigned NumWords = 12;
`endif
  localparam logic [3:0]      LastIdx = 4'(NumWords - 1);
  localparam int unsigned     CntW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [2:0] {StIdle, StCpu, StSeqReq, StSeqRel, StDone, StErr} state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [23:0]     boot_q, boot_d;
  logic [23:0]     fb_w;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            pend_q, pend_d;
  logic            acked_q, acked_d;
  logic            ack_prev_q;
  logic            s_ack_q, s_ack_d;
  logic [31:0]     s_dat_q, s_dat_d;
  logic            ack_rise;
  logic [3:0]      widx;
  logic [15:0]     word;
  logic            unused_hi;

  assign ack_rise  = m_ack_i & ~ack_prev_q;
  // CPU writes are truncated so the upper half of m_dat_o stays zero
  assign unused_hi = ^s_dat_i[31:16];

`ifdef S6_ICAP_BOOT_FALLBACK_EN
  logic [23:0] fb_q, fb_d;
  assign fb_w = fb_q;
  assign widx = idx_q;
`else
  logic unused_fb;
  assign unused_fb = ^fallback_addr;
  assign fb_w      = 24'h0;
  // Skip the four fallback words of the full stream
  assign widx      = (idx_q >= 4'd7) ? idx_q + 4'd4 : idx_q;
`endif

  always_comb begin
    word = 16'h2000;
    unique case (widx)
      4'd0:    word = 16'hFFFF;
      4'd1:    word = 16'hAA99;
      4'd2:    word = 16'h5566;
      4'd3:    word = 16'h3261;
      4'd4:    word = boot_q[15:0];
      4'd5:    word = 16'h3281;
      4'd6:    word = {FLASH_RD_OP, boot_q[23:16]};
      4'd7:    word = 16'h32A1;
      4'd8:    word = fb_w[15:0];
      4'd9:    word = 16'h32C1;
      4'd10:   word = {FLASH_RD_OP, fb_w[23:16]};
      4'd11:   word = 16'h30A1;
      4'd12:   word = 16'h000E;
      default: word = 16'h2000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    boot_d  = boot_q;
`ifdef S6_ICAP_BOOT_FALLBACK_EN
    fb_d    = fb_q;
`endif
    done_d  = done_q;
    error_d = error_q;
    pend_d  = pend_q;
    acked_d = acked_q;
    s_ack_d = 1'b0;
    s_dat_d = s_dat_q;
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_dat_o = 32'h0;
    busy    = 1'b0;
    unique case (state_q)
      StIdle: begin
        acked_d = 1'b0;
        if (start || pend_q) begin
          boot_d  = boot_addr;
`ifdef S6_ICAP_BOOT_FALLBACK_EN
          fb_d    = fallback_addr;
`endif
          done_d  = 1'b0;
          error_d = 1'b0;
          pend_d  = 1'b0;
          idx_d   = 4'd0;
          cnt_d   = '0;
          state_d = StSeqReq;
        end else if (s_cyc_i && s_stb_i) begin
          state_d = StCpu;
        end
      end
      StCpu: begin
        m_cyc_o = s_cyc_i;
        m_stb_o = s_stb_i & ~acked_q;
        m_we_o  = s_we_i;
        m_dat_o = {16'h0, s_dat_i[15:0]};
        if (start) pend_d = 1'b1;
        if (ack_rise && !acked_q) begin
          acked_d = 1'b1;
          s_ack_d = 1'b1;
          s_dat_d = m_dat_i;
        end
        if ((acked_q || !s_cyc_i) && !m_ack_i) state_d = StIdle;
      end
      StSeqReq: begin
        busy    = 1'b1;
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_dat_o = {16'h0, word};
        if (ack_rise) begin
          state_d = StSeqRel;
        end else begin
          if (cnt_q != CntMax) cnt_d = cnt_q + CntOne;
          if (cnt_d == CntMax) begin
            error_d = 1'b1;
            state_d = StErr;
          end
        end
      end
      StSeqRel: begin
        busy = 1'b1;
        // A held ack keeps us here, so each ack advances exactly one word
        if (!m_ack_i) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 4'd1;
            cnt_d   = '0;
            state_d = StSeqReq;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        if (start) pend_d = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        if (start) pend_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      cnt_q      <= '0;
      boot_q     <= 24'h0;
`ifdef S6_ICAP_BOOT_FALLBACK_EN
      fb_q       <= 24'h0;
`endif
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      pend_q     <= 1'b0;
      acked_q    <= 1'b0;
      ack_prev_q <= 1'b0;
      s_ack_q    <= 1'b0;
      s_dat_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      boot_q     <= boot_d;
`ifdef S6_ICAP_BOOT_FALLBACK_EN
      fb_q       <= fb_d;
`endif
      done_q     <= done_d;
      error_q    <= error_d;
      pend_q     <= pend_d;
      acked_q    <= acked_d;
      ack_prev_q <= m_ack_i;
      s_ack_q    <= s_ack_d;
      s_dat_q    <= s_dat_d;
    end
  end

  assign s_ack_o = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_s6_icap_boot_ctrl.sv
// Self-checking bench for s6_icap_boot_ctrl: ICAP slave model plus write scoreboard.
module tb_s6_icap_boot_ctrl;

`ifdef S6_ICAP_BOOT_FALLBACK_EN
  localparam bit FB = 1'b1;
  localparam int NW = 16;
`else
  localparam bit FB = 1'b0;
  localparam int NW = 12;
`endif

  logic        clk;
  logic        reset_n;
  logic        s_cyc_i, s_stb_i, s_we_i;
  logic [31:0] s_dat_i, s_dat_o;
  logic        s_ack_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_dat_o, m_dat_i;
  logic        m_ack_i;
  logic        start;
  logic [23:0] boot_addr, fallback_addr;
  logic        busy, done, error;

  s6_icap_boot_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_cyc_i      (s_cyc_i),
    .s_stb_i      (s_stb_i),
    .s_we_i       (s_we_i),
    .s_dat_i      (s_dat_i),
    .s_dat_o      (s_dat_o),
    .s_ack_o      (s_ack_o),
    .m_cyc_o      (m_cyc_o),
    .m_stb_o      (m_stb_o),
    .m_we_o       (m_we_o),
    .m_dat_o      (m_dat_o),
    .m_dat_i      (m_dat_i),
    .m_ack_i      (m_ack_i),
    .start        (start),
    .boot_addr    (boot_addr),
    .fallback_addr(fallback_addr),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ICAP slave model: ack 3 cycles after stb, hold ack 4 cycles; logs acked writes.
  int          dly, hold, stb_len, last_stb_len;
  logic [31:0] obs_q[$];
  bit          hang;
  int          hang_at;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_ack_i = 1'b0;
      dly     = 0;
      hold    = 0;
      stb_len = 0;
    end else begin
      if (m_stb_o) stb_len++;
      else begin
        if (stb_len != 0) last_stb_len = stb_len;
        stb_len = 0;
      end
      if (hold != 0) begin
        hold--;
        if (hold == 0) m_ack_i = 1'b0;
      end else if (m_stb_o && m_cyc_o && !(hang && obs_q.size() == hang_at)) begin
        dly++;
        if (dly == 3) begin
          m_ack_i = 1'b1;
          hold    = 4;
          dly     = 0;
          if (m_we_o) obs_q.push_back(m_dat_o);
        end
      end else begin
        dly = 0;
      end
    end
  end

  typedef struct {
    logic [23:0] boot;
    logic [23:0] fb;
    logic [31:0] w4;
    logic [31:0] w6;
    logic [31:0] w8fb;
  } seq_vec_t;

  typedef struct {
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [31:0] exp_sdat;
    logic [31:0] exp_mdat;
  } cpu_vec_t;

  seq_vec_t    seq_tbl[3];
  cpu_vec_t    cpu_tbl[4];
  logic [31:0] exp_q[$];
  logic [31:0] run_log[$];
  int          obs_rd;
  int          run_wr;
  int          n_tests;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drain();
    while (obs_rd < obs_q.size()) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: got %h, expected no write", obs_q[obs_rd]);
      end else begin
        check("sb_word", obs_q[obs_rd], exp_q.pop_front());
      end
      run_log.push_back(obs_q[obs_rd]);
      obs_rd++;
      run_wr++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    drain();
  endtask

  task automatic push_stream(input logic [23:0] b, input logic [23:0] f);
    logic [15:0] w[16];
    w = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, b[15:0], 16'h3281, {8'h0B, b[23:16]},
          16'h32A1, f[15:0], 16'h32C1, {8'h0B, f[23:16]}, 16'h30A1, 16'h000E,
          16'h2000, 16'h2000, 16'h2000};
    run_log.delete();
    run_wr = 0;
    for (int i = 0; i < 16; i++) begin
      if (FB || i < 7 || i > 10) exp_q.push_back({16'h0, w[i]});
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return done;
      1:       return error;
      2:       return busy;
      default: return s_ack_o;
    endcase
  endfunction

  task automatic wait_for(input int w, input int budget, input string name);
    int k = 0;
    while (sig(w) !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(name, {31'b0, sig(w)}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_of_run(input string name);
    check({name, "_count"}, run_wr, NW);
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_flags"}, {29'b0, busy, done, error}, 32'b010);
  endtask

  task automatic cpu_xfer(input cpu_vec_t v);
    int k = 0;
    m_dat_i = v.rdat;
    s_we_i  = v.we;
    s_dat_i = v.wdat;
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    if (v.we) exp_q.push_back(v.exp_mdat);
    while (m_ack_i !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("cpu_mdat", m_dat_o, v.exp_mdat);
    check("cpu_mwe", {31'b0, m_we_o}, {31'b0, v.we});
    check("cpu_ack_early", {31'b0, s_ack_o}, 32'd0);
    tick();
    check("cpu_ack", {31'b0, s_ack_o}, 32'd1);
    check("cpu_stb_drop", {31'b0, m_stb_o}, 32'd0);
    check("cpu_sdat", s_dat_o, v.exp_sdat);
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    tick();
    check("cpu_ack_1cyc", {31'b0, s_ack_o}, 32'd0);
    repeat (6) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int n32a1;
    seq_tbl[0] = '{24'h123456, 24'h000000, 32'h3456, 32'h0B12, 32'h0000};
    seq_tbl[1] = '{24'hABCDEF, 24'h987654, 32'hCDEF, 32'h0BAB, 32'h7654};
    seq_tbl[2] = '{24'h000001, 24'hFF8000, 32'h0001, 32'h0B00, 32'h8000};
    cpu_tbl[0] = '{1'b0, 32'h0, 32'h0000ABCD, 32'h0000ABCD, 32'h0};
    cpu_tbl[1] = '{1'b0, 32'h0, 32'h12345678, 32'h12345678, 32'h0};
    cpu_tbl[2] = '{1'b1, 32'hDEAD1234, 32'h0, 32'h0, 32'h00001234};
    cpu_tbl[3] = '{1'b1, 32'h0000FFFF, 32'h0, 32'h0, 32'h0000FFFF};

    n_tests = 0; n_fail = 0; obs_rd = 0; run_wr = 0;
    hang = 1'b0; hang_at = 0;
    reset_n = 1'b0; start = 1'b0;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0; s_dat_i = 32'h0; m_dat_i = 32'h0;
    boot_addr = 24'h0; fallback_addr = 24'h0;
    repeat (3) tick();
    check("rst_ctrl", {25'b0, m_cyc_o, m_stb_o, m_we_o, s_ack_o, busy, done, error}, 32'h0);
    check("rst_mdat", m_dat_o, 32'h0);
    check("rst_sdat", s_dat_o, 32'h0);
    reset_n = 1'b1;
    tick();

    // Reboot runs from the vector table
    for (int i = 0; i < 3; i++) begin
      push_stream(seq_tbl[i].boot, seq_tbl[i].fb);
      boot_addr     = seq_tbl[i].boot;
      fallback_addr = seq_tbl[i].fb;
      pulse_start();
      check("start_latency", {31'b0, m_stb_o}, 32'd1);
      check("first_word", m_dat_o, 32'h0000FFFF);
      wait_for(0, 400, "seq_done");
      end_of_run("seq");
      check("word4", run_log[4], seq_tbl[i].w4);
      check("word6", run_log[6], seq_tbl[i].w6);
      check("word8", run_log[8], FB ? seq_tbl[i].w8fb : 32'h000E);
      check("word_000e", run_log[FB ? 12 : 8], 32'h000E);
      n32a1 = 0;
      foreach (run_log[j]) if (run_log[j] == 32'h32A1) n32a1++;
      check("count_32a1", n32a1, FB ? 1 : 0);
      repeat (2) tick();
    end

    // CPU pass-through from the vector table
    for (int i = 0; i < 4; i++) cpu_xfer(cpu_tbl[i]);

    // Timeout on word 5, then a fresh start clears error
    hang_at = obs_q.size() + 5;
    hang = 1'b1;
    push_stream(24'h123456, 24'h0);
    boot_addr = 24'h123456;
    pulse_start();
    wait_for(1, 1200, "to_error");
    repeat (2) tick();
    check("to_flags", {30'b0, done, busy}, 32'd0);
    check("to_stb_len", last_stb_len, 1023);
    check("to_words", run_wr, 5);
    exp_q.delete();
    hang = 1'b0;
    push_stream(24'h123456, 24'h0);
    pulse_start();
    check("err_clear", {31'b0, error}, 32'd0);
    wait_for(0, 400, "to_rerun_done");
    end_of_run("to_rerun");

    // start pulsed during a CPU read is deferred until the read completes
    m_dat_i = 32'h0000ABCD; s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    tick();
    push_stream(24'h00AA55, 24'h0);
    boot_addr = 24'h00AA55;
    pulse_start();
    viol = 0;
    for (int k = 0; k < 50 && s_ack_o !== 1'b1; k++) begin
      if (busy) viol++;
      tick();
    end
    check("mid_ack", {31'b0, s_ack_o}, 32'd1);
    check("mid_sdat", s_dat_o, 32'h0000ABCD);
    check("mid_busy_early", viol, 0);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    wait_for(2, 20, "mid_busy");
    wait_for(0, 400, "mid_done");
    end_of_run("mid");

    // start and CPU request together: sequencer wins, CPU acked after done
    m_dat_i = 32'h0000BEEF; s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    push_stream(24'h654321, 24'h0);
    boot_addr = 24'h654321;
    pulse_start();
    check("sim_busy", {31'b0, busy}, 32'd1);
    viol = 0;
    for (int k = 0; k < 400 && done !== 1'b1; k++) begin
      if (s_ack_o) viol++;
      tick();
    end
    check("sim_no_early_ack", viol, 0);
    check("sim_done", {31'b0, done}, 32'd1);
    wait_for(3, 30, "sim_cpu_ack");
    check("sim_sdat", s_dat_o, 32'h0000BEEF);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    end_of_run("sim");
    repeat (6) tick();

    // Reset during word 7, then restart from word 0
    push_stream(24'h123456, 24'h0);
    boot_addr = 24'h123456;
    pulse_start();
    for (int k = 0; k < 200 && !(run_wr == 7 && m_stb_o); k++) tick();
    check("rst_reached_w7", run_wr, 7);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {25'b0, m_cyc_o, m_stb_o, m_we_o, s_ack_o, busy, done, error}, 32'h0);
    check("rst_mid_mdat", m_dat_o, 32'h0);
    check("rst_mid_sdat", s_dat_o, 32'h0);
    repeat (3) tick();
    exp_q.delete();
    reset_n = 1'b1;
    tick();
    push_stream(24'h123456, 24'h0);
    pulse_start();
    check("restart_w0", m_dat_o, 32'h0000FFFF);
    wait_for(0, 400, "restart_done");
    end_of_run("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
